trap_ctrl: RTL
==============

Name: trap_ctrl

Overview:
Trap/interrupt sequencer that sits directly downstream of the standard CSR register block.
- Consumes the CSR outputs: vector mode, vector base and interrupt-allow.
- Arbitrates pipeline exceptions, external interrupt requests and MRET.
- Drives the CSR trap-commit strobe (TRAP_EN/TRAP_CODE/TRAP_PC), then redirects fetch and holds pipeline flush for a programmable number of cycles.

Parameters:
FLUSH_CYCLES, 2, total cycles FLUSH is held per redirect (1..15)

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-low
MEM_WAIT  in  1  memory stall; blocks acceptance of new events in IDLE
EXC_EN  in  1  exception reported by execute stage (level, 1 cycle)
EXC_CODE  in  4  exception cause
EXC_PC  in  32  PC of faulting instruction
INT_REQ  in  1  external interrupt request (level)
INT_CAUSE  in  4  interrupt cause
CUR_PC  in  32  PC of oldest uncommitted instruction (interrupt return address)
MRET_EN  in  1  MRET executed
MEPC  in  32  current mepc from CSR block
INT_ALLOW  in  1  mstatus.MIE from CSR block
TRAP_VEC_MODE  in  2  mtvec mode from CSR block
TRAP_VEC_BASE  in  32  mtvec base (low 2 bits zero) from CSR block
TRAP_EN  out  1  trap commit strobe to CSR block
TRAP_CODE  out  32  mcause value
TRAP_PC  out  32  mepc value
STALL  out  1  pipeline stall
FLUSH  out  1  pipeline flush
JUMP_EN  out  1  fetch redirect strobe
JUMP_PC  out  32  fetch redirect target

Behaviour:
- Reset: RST==0 sampled at posedge. State=IDLE, int_pend=0, drain counter=0; all outputs 0.
- States: IDLE, COMMIT, REDIRECT, DRAIN.
- int_pend / int_cause_q:
  - Set on any cycle with INT_REQ=1 and int_pend=0; INT_CAUSE captured on that same cycle.
  - Later INT_CAUSE changes are ignored while pend=1.
  - Cleared when the interrupt is taken; clear has priority over a same-cycle set.
- IDLE, only when MEM_WAIT=0, priority exception > interrupt > MRET:
  - EXC_EN=1: code_q={28'b0,EXC_CODE}, pc_q=EXC_PC, is_int=0 → COMMIT.
  - else int_pend=1 and INT_ALLOW=1: code_q={1'b1,27'b0,int_cause_q}, pc_q=CUR_PC, is_int=1, int_pend cleared → COMMIT.
  - else MRET_EN=1: target_q=MEPC → REDIRECT, with no TRAP_EN.
  - MEM_WAIT=1: remain IDLE, ignore events. EXC_EN/MRET_EN must be re-presented by the pipeline; int_pend persists.
- COMMIT (exactly 1 cycle):
  - TRAP_EN=1, TRAP_CODE=code_q, TRAP_PC=pc_q, STALL=1.
  - Target computation:
    - TRAP_VEC_MODE==2'b01 and is_int: target_q=TRAP_VEC_BASE+(int_cause_q<<2), 32-bit wrap.
    - Otherwise target_q=TRAP_VEC_BASE. Modes 2'b10/2'b11 are treated as direct.
  - → REDIRECT.
- REDIRECT (1 cycle):
  - JUMP_EN=1, JUMP_PC=target_q, FLUSH=1.
  - FLUSH_CYCLES==1 → IDLE. Otherwise load counter=FLUSH_CYCLES-2 and go to DRAIN.
- DRAIN: FLUSH=1, JUMP_EN=0. Counter decrements each cycle; leave for IDLE in the cycle the counter is 0.
- EXC_EN and MRET_EN outside IDLE are ignored (the instructions are being flushed). INT_REQ still sets int_pend in any state.
- Outputs are registered from state; TRAP_CODE/TRAP_PC/JUMP_PC are 0 when their strobes are 0.
- Latency: event accepted at edge N → TRAP_EN high in cycle N+1, JUMP_EN in N+2. FLUSH spans N+2 .. N+1+FLUSH_CYCLES.
- MRET path: JUMP_EN at N+1.
- Back-to-back: the earliest new acceptance is the first cycle after FLUSH deasserts.
- Reset mid-sequence: immediate return to IDLE. TRAP_EN/JUMP_EN/FLUSH deassert in the next cycle and no partial strobe is repeated.

Test Plan:
- Exception, direct mode: TRAP_VEC_MODE=0, BASE=0x100, EXC_EN with CODE=2, PC=0x40 → one-cycle TRAP_EN, CODE=0x2, PC=0x40; next cycle JUMP_EN with JUMP_PC=0x100; FLUSH high 2 cycles.
- Vectored interrupt: MODE=1, BASE=0x200, INT_ALLOW=1, INT_REQ with CAUSE=11, CUR_PC=0x88 → TRAP_CODE=0x8000000B, TRAP_PC=0x88, JUMP_PC=0x22C; int_pend cleared.
- Masked then allowed: INT_REQ pulse while INT_ALLOW=0 for 10 cycles → no TRAP_EN. Raise INT_ALLOW → TRAP_EN the cycle after, using the cause captured at the pulse.
- Priority: EXC_EN (CODE=3, PC=0x10) and pending allowed interrupt in the same IDLE cycle → exception taken first, code 0x3. Interrupt taken in the first cycle after FLUSH drops.
- MRET with MEPC=0x1234 → no TRAP_EN, JUMP_EN next cycle with JUMP_PC=0x1234. EXC_EN asserted during FLUSH is ignored.
- MEM_WAIT=1 with EXC_EN held 3 cycles → no action; MEM_WAIT drops → accepted. Separately, RST=0 during REDIRECT → all outputs 0 the next cycle, state IDLE.

Source files
------------

// File: rtl/trap_ctrl.sv
// Trap/interrupt sequencer between the CSR block and the pipeline front end.
// Arbitrates exceptions, interrupts and MRET, commits traps, redirects fetch and drains the pipe.
module trap_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MEM_WAIT,
    input  logic        EXC_EN,
    input  logic [3:0]  EXC_CODE,
    input  logic [31:0] EXC_PC,
    input  logic        INT_REQ,
    input  logic [3:0]  INT_CAUSE,
    input  logic [31:0] CUR_PC,
    input  logic        MRET_EN,
    input  logic [31:0] MEPC,
    input  logic        INT_ALLOW,
    input  logic [1:0]  TRAP_VEC_MODE,
    input  logic [31:0] TRAP_VEC_BASE,
    output logic        TRAP_EN,
    output logic [31:0] TRAP_CODE,
    output logic [31:0] TRAP_PC,
    output logic        STALL,
    output logic        FLUSH,
    output logic        JUMP_EN,
    output logic [31:0] JUMP_PC
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_COMMIT   = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;
    localparam logic [1:0] ST_DRAIN    = 2'd3;

    localparam logic [3:0] DRAIN_LOAD = (FLUSH_CYCLES >= 2) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
    localparam logic       SINGLE_FLUSH = (FLUSH_CYCLES == 1) ? 1'b1 : 1'b0;

    logic [1:0]  state_r,     state_s;
    logic        int_pend_r,  int_pend_s;
    logic [3:0]  int_cause_r, int_cause_s;
    logic        is_int_r,    is_int_s;
    logic [3:0]  cnt_r,       cnt_s;
    logic        take_int_s;
    logic [31:0] target_s;

    logic        trap_en_r,   trap_en_s;
    logic [31:0] trap_code_r, trap_code_s;
    logic [31:0] trap_pc_r,   trap_pc_s;
    logic        stall_r,     stall_s;
    logic        flush_r,     flush_s;
    logic        jump_en_r,   jump_en_s;
    logic [31:0] jump_pc_r,   jump_pc_s;

    // Trap target: vectored mode offsets interrupts by cause*4, everything else goes to base.
    always_comb begin
        if ((TRAP_VEC_MODE == 2'b01) && is_int_r) begin
            target_s = TRAP_VEC_BASE + {26'd0, int_cause_r, 2'b00};
        end else begin
            target_s = TRAP_VEC_BASE;
        end
    end

    // Next-state and next-output computation; outputs are all registered from these.
    always_comb begin
        state_s     = state_r;
        is_int_s    = is_int_r;
        cnt_s       = cnt_r;
        take_int_s  = 1'b0;
        trap_en_s   = 1'b0;
        trap_code_s = 32'd0;
        trap_pc_s   = 32'd0;
        stall_s     = 1'b0;
        flush_s     = 1'b0;
        jump_en_s   = 1'b0;
        jump_pc_s   = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (!MEM_WAIT) begin
                    if (EXC_EN) begin
                        state_s     = ST_COMMIT;
                        is_int_s    = 1'b0;
                        trap_en_s   = 1'b1;
                        trap_code_s = {28'd0, EXC_CODE};
                        trap_pc_s   = EXC_PC;
                        stall_s     = 1'b1;
                    end else if (int_pend_r && INT_ALLOW) begin
                        state_s     = ST_COMMIT;
                        is_int_s    = 1'b1;
                        take_int_s  = 1'b1;
                        trap_en_s   = 1'b1;
                        trap_code_s = {1'b1, 27'd0, int_cause_r};
                        trap_pc_s   = CUR_PC;
                        stall_s     = 1'b1;
                    end else if (MRET_EN) begin
                        state_s   = ST_REDIRECT;
                        jump_en_s = 1'b1;
                        jump_pc_s = MEPC;
                        flush_s   = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                state_s   = ST_REDIRECT;
                jump_en_s = 1'b1;
                jump_pc_s = target_s;
                flush_s   = 1'b1;
            end
            ST_REDIRECT: begin
                if (SINGLE_FLUSH) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                    cnt_s   = DRAIN_LOAD;
                    flush_s = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                    flush_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Pending interrupt latch: taking the interrupt wins over a same-cycle new request.
    always_comb begin
        int_pend_s  = int_pend_r;
        int_cause_s = int_cause_r;
        if (take_int_s) begin
            int_pend_s = 1'b0;
        end else if (INT_REQ && !int_pend_r) begin
            int_pend_s  = 1'b1;
            int_cause_s = INT_CAUSE;
        end else begin
            int_pend_s = int_pend_r;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r     <= ST_IDLE;
            int_pend_r  <= 1'b0;
            int_cause_r <= 4'd0;
            is_int_r    <= 1'b0;
            cnt_r       <= 4'd0;
            trap_en_r   <= 1'b0;
            trap_code_r <= 32'd0;
            trap_pc_r   <= 32'd0;
            stall_r     <= 1'b0;
            flush_r     <= 1'b0;
            jump_en_r   <= 1'b0;
            jump_pc_r   <= 32'd0;
        end else begin
            state_r     <= state_s;
            int_pend_r  <= int_pend_s;
            int_cause_r <= int_cause_s;
            is_int_r    <= is_int_s;
            cnt_r       <= cnt_s;
            trap_en_r   <= trap_en_s;
            trap_code_r <= trap_code_s;
            trap_pc_r   <= trap_pc_s;
            stall_r     <= stall_s;
            flush_r     <= flush_s;
            jump_en_r   <= jump_en_s;
            jump_pc_r   <= jump_pc_s;
        end
    end

    assign TRAP_EN   = trap_en_r;
    assign TRAP_CODE = trap_code_r;
    assign TRAP_PC   = trap_pc_r;
    assign STALL     = stall_r;
    assign FLUSH     = flush_r;
    assign JUMP_EN   = jump_en_r;
    assign JUMP_PC   = jump_pc_r;

endmodule
